// File: rtl/mole_pkg.sv
// mole_pkg: shared state encoding and field widths for the whack-a-mole round sequencer.
package mole_pkg;
  localparam int ADDR_W = 4;
  localparam int POS_W = 4;
  localparam int SCORE_W = 8;
  typedef enum logic [2:0] {IDLE, FILL, LOAD, SHOW, ADV, DONE} state_e;
endpackage

// File: rtl/mole_window_timer.sv
// mole_window_timer: counts cycles a mole is up and flags the last one.
// Build option SPEEDUP_EN: the limit shrinks by WINDOW>>4 per correct hit, floored at MIN_WINDOW.
module mole_window_timer #(
  parameter int WINDOW = 50000000,
  parameter int MIN_WINDOW = 12500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic load_i,
  input  logic en_i,
  input  logic shrink_i,
  output logic expire_o
);
  localparam int CW = $clog2(WINDOW + 1);
  logic [CW-1:0] cnt_q, limit;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || load_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  end
  assign expire_o = en_i && cnt_q == limit - 1'b1;
`ifdef SPEEDUP_EN
  localparam logic [CW-1:0] WIN = CW'(WINDOW);
  localparam logic [CW-1:0] FLOOR = CW'(MIN_WINDOW);
  localparam logic [CW-1:0] STEP = CW'(WINDOW >> 4);
  logic [CW-1:0] limit_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) limit_q <= WIN;
    else if (shrink_i) limit_q <= limit_q < FLOOR + STEP ? FLOOR : limit_q - STEP;
  end
  assign limit = limit_q;
`else
  logic unused_ok;
  assign unused_ok = clear_i | shrink_i;
  assign limit = CW'(WINDOW);
`endif
endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: fills the pseudo_rng store, then replays it as timed mole windows and scores hits.
// Build option SPEEDUP_EN (handled in mole_window_timer): window shrinks on every correct hit.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int POS_COUNT = 6,
  parameter int GEN_GAP = 7,
  parameter int RD_LAT = 2,
  parameter int WINDOW = 50000000,
  parameter int MIN_WINDOW = 12500000
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               hit_valid_i,
  input  logic [POS_W-1:0]   hit_pos_i,
  input  logic [POS_W-1:0]   rng_data_i,
  output logic               rng_generate_o,
  output logic [ADDR_W-1:0]  rng_address_o,
  output logic               mole_valid_o,
  output logic [POS_W-1:0]   mole_pos_o,
  output logic               hit_ok_o,
  output logic               miss_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               busy_o,
  output logic               round_done_o
);
  localparam int PH_MAX = GEN_GAP > RD_LAT ? GEN_GAP : RD_LAT;
  localparam int PW = $clog2(PH_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [PW-1:0] GAP_END = PW'(GEN_GAP);
  localparam logic [PW-1:0] LAT_END = PW'(RD_LAT);
  localparam logic [POS_W-1:0] POS_LIM = POS_W'(POS_COUNT);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic hit_ok_q, hit_ok_d, miss_q, miss_d;
  logic restart, tmr_load, expire;
  assign restart = start_i && (state_q == IDLE || state_q == DONE);
  // ph_q paces the generate strobe in FILL and the read latency in LOAD
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    ph_d = ph_q;
    pos_d = pos_q;
    score_d = score_q;
    hit_ok_d = 1'b0;
    miss_d = 1'b0;
    tmr_load = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (restart) begin
          state_d = FILL;
          idx_d = '0;
          ph_d = '0;
          score_d = '0;
        end
      end
      FILL: begin
        ph_d = ph_q == GAP_END ? '0 : ph_q + 1'b1;
        if (ph_q == GAP_END) begin
          state_d = idx_q == LAST ? LOAD : FILL;
          idx_d = idx_q == LAST ? '0 : idx_q + 1'b1;
        end
      end
      LOAD: begin
        ph_d = ph_q == LAT_END ? '0 : ph_q + 1'b1;
        if (ph_q == LAT_END) begin
          state_d = rng_data_i < POS_LIM ? SHOW : ADV;
          pos_d = rng_data_i;
          tmr_load = 1'b1;
        end
      end
      SHOW: begin
        hit_ok_d = hit_valid_i && hit_pos_i == pos_q;
        miss_d = !hit_ok_d && (hit_valid_i || expire);
        score_d = hit_ok_d && score_q != '1 ? score_q + 1'b1 : score_q;
        state_d = hit_ok_d || expire ? ADV : SHOW;
      end
      ADV: begin
        state_d = idx_q == LAST ? DONE : LOAD;
        idx_d = idx_q == LAST ? idx_q : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      idx_q <= '0;
      ph_q <= '0;
      pos_q <= '0;
      score_q <= '0;
      hit_ok_q <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      ph_q <= ph_d;
      pos_q <= pos_d;
      score_q <= score_d;
      hit_ok_q <= hit_ok_d;
      miss_q <= miss_d;
    end
  end
  mole_window_timer #(
    .WINDOW(WINDOW),
    .MIN_WINDOW(MIN_WINDOW)
  ) u_timer (
    .clk_i(clock_i),
    .rst_ni(reset_i),
    .clear_i(restart),
    .load_i(tmr_load),
    .en_i(state_q == SHOW),
    .shrink_i(hit_ok_d),
    .expire_o(expire)
  );
  assign rng_generate_o = state_q == FILL && ph_q == '0;
  assign rng_address_o = idx_q;
  assign mole_valid_o = state_q == SHOW;
  assign mole_pos_o = mole_valid_o ? pos_q : '0;
  assign hit_ok_o = hit_ok_q;
  assign miss_o = miss_q;
  assign score_o = score_q;
  assign busy_o = !(state_q == IDLE || state_q == DONE);
  assign round_done_o = state_q == DONE;
endmodule
